// File: rtl/matrix_column_scanner.sv
// -----------------------------------------------------------------------------
// matrix_column_scanner
//
// Multiplexes five 7-bit column patterns onto a 5x7 LED matrix, one column at
// a time. The patterns are snapshotted at the start of every frame, so a
// single frame never shows a mix of two boards. Each column slot is SCAN_DIV
// cycles: BLANK_CYCLES cycles with every column off (anti-ghosting), then
// the column is driven for the rest of the slot.
//
// Optional feature (macro CURSOR_BLINK_EN): the cursor position is
// snapshotted together with the board. On alternate groups of BLINK_FRAMES
// frames the row bit under the cursor is inverted.
//
// Ports:
//   clk          system clock
//   reset        synchronous reset, active-high
//   enable       scan enable; low keeps the matrix dark and the scanner idle
//   col1_in..col5_in  column patterns, bit i = row i (bit 0 = top), 1 = on
//   cursor_col   cursor column 0..4, 5..7 = none   (CURSOR_BLINK_EN only)
//   cursor_row   cursor row 0..6, 7 = none         (CURSOR_BLINK_EN only)
//   matrix_col   column select, active-low, bit 0 = column 1
//   matrix_row   row data, active-high
//   frame_start  one-cycle pulse in the first cycle of every frame
//   col_idx      column currently being scanned, 0..4
// -----------------------------------------------------------------------------
module matrix_column_scanner #(
  parameter int SCAN_DIV     = 50000,
  parameter int BLANK_CYCLES = 2,
  parameter int BLINK_FRAMES = 32
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic [6:0] col1_in,
  input  logic [6:0] col2_in,
  input  logic [6:0] col3_in,
  input  logic [6:0] col4_in,
  input  logic [6:0] col5_in,
`ifdef CURSOR_BLINK_EN
  input  logic [2:0] cursor_col,
  input  logic [2:0] cursor_row,
`endif
  output logic [4:0] matrix_col,
  output logic [6:0] matrix_row,
  output logic       frame_start,
  output logic [2:0] col_idx
);

  localparam int PW = $clog2(SCAN_DIV);
  localparam logic [PW-1:0] PRE_LAST  = PW'(SCAN_DIV - 1);
  localparam logic [PW-1:0] PRE_BLANK = PW'(BLANK_CYCLES);

  // Parameter sanity is checked at elaboration so a bad build never exists.
  if (BLANK_CYCLES < 1 || SCAN_DIV < BLANK_CYCLES + 1 || BLINK_FRAMES < 1) begin : g_param_check
    $error("matrix_column_scanner: illegal SCAN_DIV/BLANK_CYCLES/BLINK_FRAMES");
  end

  typedef enum logic [1:0] {IDLE, BLANK, DRIVE} state_t;

  state_t        state, state_n;
  logic [PW-1:0] prescaler, prescaler_n;
  logic [2:0]    col_idx_n;
  logic          frame_start_n;
  logic          load;        // capture a fresh snapshot this edge
  logic          frame_tick;  // a full frame has just completed
  logic [6:0]    snapshot [5];
  logic [6:0]    cur_data;

  // ---------------------------------------------------------------------------
  // Next-state logic
  // NOTE: every signal gets a default first so no path leaves one unassigned;
  // otherwise synthesis would infer a latch to hold the old value.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_n       = state;
    prescaler_n   = prescaler;
    col_idx_n     = col_idx;
    frame_start_n = 1'b0;
    load          = 1'b0;
    frame_tick    = 1'b0;

    if (!enable) begin
      // Disable wins over everything else, including a frame boundary.
      state_n     = IDLE;
      prescaler_n = '0;
      col_idx_n   = '0;
    end else if (state == IDLE) begin
      state_n       = BLANK;
      prescaler_n   = '0;
      col_idx_n     = '0;
      load          = 1'b1;
      frame_start_n = 1'b1;
    end else if (prescaler == PRE_LAST) begin
      state_n     = BLANK;
      prescaler_n = '0;
      if (col_idx == 3'd4) begin
        col_idx_n     = '0;
        load          = 1'b1;
        frame_start_n = 1'b1;
        frame_tick    = 1'b1;
      end else begin
        col_idx_n = col_idx + 3'd1;
      end
    end else begin
      prescaler_n = prescaler + PW'(1);
      state_n     = (prescaler_n < PRE_BLANK) ? BLANK : DRIVE;
    end
  end

  // ---------------------------------------------------------------------------
  // State registers
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      prescaler   <= '0;
      col_idx     <= '0;
      frame_start <= 1'b0;
    end else begin
      state       <= state_n;
      prescaler   <= prescaler_n;
      col_idx     <= col_idx_n;
      frame_start <= frame_start_n;
    end
  end

  // NOTE: the snapshot is cleared on reset on purpose: its contents are
  // observable on the pins, so it must never start out undefined.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 5; i++) snapshot[i] <= '0;
    end else if (load) begin
      snapshot[0] <= col1_in;
      snapshot[1] <= col2_in;
      snapshot[2] <= col3_in;
      snapshot[3] <= col4_in;
      snapshot[4] <= col5_in;
    end
  end

  // Column data for the current slot; col_idx never exceeds 4.
  always_comb begin
    case (col_idx)
      3'd0:    cur_data = snapshot[0];
      3'd1:    cur_data = snapshot[1];
      3'd2:    cur_data = snapshot[2];
      3'd3:    cur_data = snapshot[3];
      default: cur_data = snapshot[4];
    endcase
  end

`ifdef CURSOR_BLINK_EN
  localparam int BW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  logic [BW-1:0] blink_cnt;
  logic          blink_phase;
  logic [2:0]    snap_ccol;
  logic [2:0]    snap_crow;
  logic          cursor_hit;

  always_ff @(posedge clk) begin
    if (reset) begin
      blink_cnt   <= '0;
      blink_phase <= 1'b0;
      snap_ccol   <= 3'd7;
      snap_crow   <= 3'd7;
    end else begin
      if (load) begin
        snap_ccol <= cursor_col;
        snap_crow <= cursor_row;
      end
      if (frame_tick) begin
        if (blink_cnt == BW'(BLINK_FRAMES - 1)) begin
          blink_cnt   <= '0;
          blink_phase <= ~blink_phase;
        end else begin
          blink_cnt <= blink_cnt + BW'(1);
        end
      end
    end
  end

  assign cursor_hit = blink_phase && (snap_ccol <= 3'd4) && (snap_crow <= 3'd6) &&
                      (snap_ccol == col_idx);
`endif

  // Outputs are decoded from registered state only.
  always_comb begin
    matrix_col = 5'b11111;
    matrix_row = 7'b0;
    if (state == DRIVE) begin
      matrix_col = ~(5'b00001 << col_idx);
      matrix_row = cur_data;
`ifdef CURSOR_BLINK_EN
      if (cursor_hit) matrix_row = cur_data ^ (7'b0000001 << snap_crow);
`endif
    end
  end

endmodule

// File: tb/tb_matrix_column_scanner.sv
// -----------------------------------------------------------------------------
// tb_matrix_column_scanner
//
// Directed scenarios followed by randomized traffic. Expected pin values come
// from a behavioural model that tracks "time since frame start" and the
// captured board, then derives column/row/pulse values arithmetically.
// -----------------------------------------------------------------------------
module tb_matrix_column_scanner;

  localparam int SD = 8;
  localparam int BC = 2;
  localparam int BF = 2;

  logic       clk = 1'b0;
  logic       reset;
  logic       enable;
  logic [6:0] cols [5];
  logic [4:0] matrix_col;
  logic [6:0] matrix_row;
  logic       frame_start;
  logic [2:0] col_idx;
`ifdef CURSOR_BLINK_EN
  logic [2:0] cursor_col;
  logic [2:0] cursor_row;
`endif

  always #5 clk = ~clk;

  matrix_column_scanner #(
    .SCAN_DIV    (SD),
    .BLANK_CYCLES(BC),
    .BLINK_FRAMES(BF)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .enable     (enable),
    .col1_in    (cols[0]),
    .col2_in    (cols[1]),
    .col3_in    (cols[2]),
    .col4_in    (cols[3]),
    .col5_in    (cols[4]),
`ifdef CURSOR_BLINK_EN
    .cursor_col (cursor_col),
    .cursor_row (cursor_row),
`endif
    .matrix_col (matrix_col),
    .matrix_row (matrix_row),
    .frame_start(frame_start),
    .col_idx    (col_idx)
  );

  int errors = 0;
  int checks = 0;

  // Reference model state.
  bit         m_run;       // a frame is in progress
  int         m_t;         // cycles since the current frame started
  int         m_frames;    // completed frames since reset
  logic [6:0] m_snap [5];
  int         m_ccol;
  int         m_crow;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic capture();
    for (int i = 0; i < 5; i++) m_snap[i] = cols[i];
`ifdef CURSOR_BLINK_EN
    m_ccol = int'(cursor_col);
    m_crow = int'(cursor_row);
`endif
  endtask

  // Advance the model by one clock edge using the inputs the DUT just sampled.
  task automatic model_edge();
    if (reset) begin
      m_run = 0; m_t = 0; m_frames = 0;
      for (int i = 0; i < 5; i++) m_snap[i] = '0;
      m_ccol = 7; m_crow = 7;
    end else if (!enable) begin
      m_run = 0; m_t = 0;
    end else if (!m_run) begin
      m_run = 1; m_t = 0;
      capture();
    end else begin
      m_t++;
      if (m_t == 5 * SD) begin
        m_t = 0;
        m_frames++;
        capture();
      end
    end
  endtask

  task automatic compare();
    logic [4:0] e_col;
    logic [6:0] e_row;
    logic       e_fs;
    int         e_idx;
    e_col = 5'b11111; e_row = '0; e_fs = 1'b0; e_idx = 0;
    if (m_run) begin
      e_idx = m_t / SD;
      e_fs  = (m_t == 0);
      if ((m_t % SD) >= BC) begin
        e_col = 5'b11111;
        e_col[e_idx] = 1'b0;
        e_row = m_snap[e_idx];
`ifdef CURSOR_BLINK_EN
        if (((m_frames / BF) % 2 == 1) && m_ccol <= 4 && m_crow <= 6 && m_ccol == e_idx)
          e_row[m_crow] = ~e_row[m_crow];
`endif
      end
    end
    check("matrix_col",  32'(matrix_col),  32'(e_col));
    check("matrix_row",  32'(matrix_row),  32'(e_row));
    check("frame_start", 32'(frame_start), 32'(e_fs));
    check("col_idx",     32'(col_idx),     32'(e_idx));
  endtask

  // One clock: edge, model update, sample 1 ns later, return at the next negedge.
  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    compare();
    @(negedge clk);
  endtask

  task automatic set_board(input logic [6:0] a, b, c, d, e);
    cols[0] = a; cols[1] = b; cols[2] = c; cols[3] = d; cols[4] = e;
  endtask

  initial begin
    int guard;
    reset = 1'b1;
    enable = 1'b0;
    set_board('0, '0, '0, '0, '0);
`ifdef CURSOR_BLINK_EN
    cursor_col = 3'd7;
    cursor_row = 3'd7;
`endif

    // Reset held with enable low, then dark for 20 cycles.
    repeat (3) tick();
    reset = 1'b0;
    repeat (20) tick();

    // First board; enable rises. Cycle 0 is the first edge with enable high.
    set_board(7'b0111100, 7'b0011101, 7'b0110101, 7'b1000111, 7'b1110111);
    enable = 1'b1;
    repeat (12) tick();
    // Mid-frame input change: ignored until the frame boundary at cycle 40.
    set_board(7'b0001101, 7'b1011100, 7'b1011101, 7'b1110111, 7'b1000111);
    repeat (40) tick();

    // Drop enable during column 3 DRIVE, then re-enable.
    guard = 0;
    while (!(m_run && m_t == 2 * SD + BC + 2) && guard < 100) begin tick(); guard++; end
    check("reach_col3_drive", 32'(guard < 100), 32'd1);
    enable = 1'b0;
    repeat (3) tick();
    set_board(7'b1010101, 7'b0101010, 7'b1111111, 7'b0000001, 7'b1000000);
    enable = 1'b1;
    repeat (20) tick();

    // One-cycle reset during column 4 DRIVE with enable still high.
    guard = 0;
    while (!(m_run && m_t == 3 * SD + BC + 1) && guard < 100) begin tick(); guard++; end
    check("reach_col4_drive", 32'(guard < 100), 32'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    repeat (45) tick();

`ifdef CURSOR_BLINK_EN
    // Cursor on column 3 row 3 across six frames, then an off-board cursor.
    set_board(7'b0111100, 7'b0011101, 7'b0110101, 7'b1000111, 7'b1110111);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    cursor_col = 3'd2;
    cursor_row = 3'd3;
    repeat (6 * 5 * SD) tick();
    cursor_col = 3'd5;
    repeat (4 * 5 * SD) tick();
`endif

    // Randomized traffic: new boards, short enable drops, rare resets.
    for (int n = 0; n < 2500; n++) begin
      if ($urandom_range(0, 6) == 0)
        set_board(7'($urandom), 7'($urandom), 7'($urandom), 7'($urandom), 7'($urandom));
`ifdef CURSOR_BLINK_EN
      if ($urandom_range(0, 30) == 0) begin
        cursor_col = 3'($urandom);
        cursor_row = 3'($urandom);
      end
`endif
      enable = ($urandom_range(0, 60) != 0);
      reset  = ($urandom_range(0, 300) == 0);
      tick();
    end
    reset = 1'b0;
    enable = 1'b1;
    repeat (5) tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
